// File: rtl/memory_responder.sv
// Memory-side responder for the memEN/RW/MFC handshake: latches one request,
// waits LATENCY edges, performs the RAM access and holds MFC until memEN drops.
module memory_responder #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_mem_en,
    input  logic              i_rw,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data_in,
    output logic [DATA_W-1:0] o_data_out,
    output logic              o_mfc,
    output logic              o_busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_mfc;
    logic              r_busy;
    logic [DATA_W-1:0] r_data_out;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rw;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_mem [0:(1 << ADDR_W) - 1];

    logic [1:0]        w_state_nxt;
    logic [3:0]        w_cnt_nxt;
    logic              w_accept;
    logic              w_complete;

    // Next-state and counter logic; w_complete marks the edge that performs the access.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_mem_en) begin
                    w_state_nxt = ST_BUSY;
                    w_cnt_nxt   = 4'd0;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!i_mem_en) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt == LAT_LAST) begin
                    w_state_nxt = ST_ACK;
                    w_cnt_nxt   = 4'd0;
                    w_complete  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + 4'd1;
                end
            end
            ST_ACK: begin
                if (!i_mem_en) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ACK;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Control state, request capture and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_mfc      <= 1'b0;
            r_busy     <= 1'b0;
            r_data_out <= {DATA_W{1'b0}};
            r_addr     <= {ADDR_W{1'b0}};
            r_rw       <= 1'b0;
            r_data     <= {DATA_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mfc   <= (w_state_nxt == ST_ACK);
            r_busy  <= (w_state_nxt != ST_IDLE);
            if (w_accept) begin
                r_addr <= i_addr;
                r_rw   <= i_rw;
                r_data <= i_data_in;
            end
            // dataOut only moves on a completed read, so the initiator may latch it late.
            if (w_complete && r_rw) begin
                r_data_out <= r_mem[r_addr];
            end
        end
    end

    // RAM array is deliberately not reset; reset forces IDLE so no write can commit.
    always_ff @(posedge i_clk) begin
        if (w_complete && !r_rw) begin
            r_mem[r_addr] <= r_data;
        end
    end

    assign o_data_out = r_data_out;
    assign o_mfc      = r_mfc;
    assign o_busy     = r_busy;

endmodule
